// File: rtl/calc_arbiter_if.sv
// Bundle of requester command/response channels, calculator-core drive lines and status.
// The slave modport is the arbiter's view; master is the environment (requesters and core).
interface calc_arbiter_if #(
    parameter int NREQ = 2,
    parameter int W    = 8
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [2*NREQ-1:0] req_op;
    logic [W*NREQ-1:0] req_num;
    logic [NREQ-1:0]   resp_valid;
    logic [NREQ-1:0]   resp_ready;
    logic [W-1:0]      resp_data;
    logic [W-1:0]      calc_num;
    logic [1:0]        calc_op;
    logic              calc_enter;
    logic [W-1:0]      calc_result;
    logic              busy;
    logic [7:0]        txn_count;

    modport slave (
        input  req_valid, req_op, req_num, resp_ready, calc_result,
        output req_ready, resp_valid, resp_data, calc_num, calc_op, calc_enter, busy, txn_count
    );

    modport master (
        output req_valid, req_op, req_num, resp_ready, calc_result,
        input  req_ready, resp_valid, resp_data, calc_num, calc_op, calc_enter, busy, txn_count
    );
endinterface

// File: rtl/calc_arbiter.sv
// Round-robin arbiter that serialises requester commands into a shared accumulator core
// and returns the core's updated accumulator to the granted requester.
module calc_arbiter #(
    parameter int NREQ = 2,
    parameter int W    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    calc_arbiter_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, RESP} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    logic [W-1:0]    num_q, num_d;
    logic [1:0]      op_q, op_d;
    logic [W-1:0]    data_q, data_d;
    logic [7:0]      txn_q, txn_d;
    logic            enter_q;

    logic [PW-1:0]   pick;
    logic            any_valid;
    logic            accept;
    logic [PW:0]     scan_idx;
    logic [1:0]      op_arr  [NREQ];
    logic [W-1:0]    num_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign op_arr[gi]  = bus.req_op[2*gi+1:2*gi];
        assign num_arr[gi] = bus.req_num[W*gi+W-1:W*gi];
        assign bus.req_ready[gi]  = accept && rst_n && (pick == PW'(gi));
        assign bus.resp_valid[gi] = (state_q == RESP) && (gnt_q == PW'(gi));
    end

    // Scan from the farthest offset down so the nearest requester at or after ptr wins.
    always_comb begin
        pick      = '0;
        any_valid = 1'b0;
        scan_idx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_idx = {1'b0, ptr_q} + (PW+1)'(k);
            if (scan_idx >= (PW+1)'(NREQ)) begin
                scan_idx = scan_idx - (PW+1)'(NREQ);
            end
            if (bus.req_valid[scan_idx[PW-1:0]]) begin
                pick      = scan_idx[PW-1:0];
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        num_d   = num_q;
        op_d    = op_q;
        data_d  = data_q;
        txn_d   = txn_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    accept  = 1'b1;
                    gnt_d   = pick;
                    ptr_d   = (pick == PW'(NREQ - 1)) ? '0 : pick + 1'b1;
                    op_d    = op_arr[pick];
                    num_d   = num_arr[pick];
                    state_d = ISSUE;
                end
            end
            ISSUE:  state_d = SETTLE;
            SETTLE: begin
                // Core updated its accumulator on the edge closing ISSUE.
                data_d  = bus.calc_result;
                state_d = RESP;
            end
            RESP: begin
                if (bus.resp_ready[gnt_q]) begin
                    txn_d   = txn_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            num_q   <= '0;
            op_q    <= '0;
            data_q  <= '0;
            txn_q   <= '0;
            enter_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            num_q   <= num_d;
            op_q    <= op_d;
            data_q  <= data_d;
            txn_q   <= txn_d;
            enter_q <= (state_d == ISSUE);
        end
    end

    assign bus.resp_data  = data_q;
    assign bus.calc_num   = num_q;
    assign bus.calc_op    = op_q;
    assign bus.calc_enter = enter_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.txn_count  = txn_q;
endmodule

// File: tb/tb_calc_arbiter.sv
// Directed bench for calc_arbiter: stub accumulator core, transaction-timing reference model
// compared every cycle, plus literal expectations for each scenario.
module tb_calc_arbiter;
    localparam int NREQ = 2;
    localparam int W    = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    calc_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();
    calc_arbiter #(.NREQ(NREQ), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Requester stimulus
    int             rem     [NREQ];
    logic [1:0]     cmd_op  [NREQ];
    logic [W-1:0]   cmd_num [NREQ];
    logic [NREQ-1:0] rready;

    // Stub of the accumulator core
    logic [W-1:0] core_acc;
    logic         core_load;
    logic [W-1:0] core_load_val;

    function automatic logic [W-1:0] calc(input logic [W-1:0] a, input logic [1:0] op,
                                          input logic [W-1:0] n);
        case (op)
            2'd0:    return a + n;
            2'd1:    return a - n;
            2'd2:    return a | n;
            default: return (a == n) ? W'(1) : W'(0);
        endcase
    endfunction

    always @(posedge clk) begin
        if (core_load) core_acc <= core_load_val;
        else if (bus.calc_enter) core_acc <= calc(core_acc, bus.calc_op, bus.calc_num);
    end
    assign bus.calc_result = core_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a transaction is described by its grant and its age since acceptance.
    bit           m_valid = 1'b0;
    bit           m_active;
    int           m_age, m_g, m_ptr;
    logic [W-1:0] m_shown, m_pending, m_num, ref_acc;
    logic [1:0]   m_op;
    logic [7:0]   m_cnt;
    int           grant_q[$];
    int           acc_cyc_q[$];
    int           hs_cyc_q[$];
    int           data_q[$];

    function automatic int rr_pick();
        for (int k = 0; k < NREQ; k++) begin
            if (bus.req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int p;
        cyc++;
        if (core_load) ref_acc = core_load_val;
        if (!rst_n) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_age    = 0;
            m_g      = 0;
            m_ptr    = 0;
            m_shown  = '0;
            m_num    = '0;
            m_op     = '0;
            m_cnt    = '0;
        end else if (m_valid) begin
            if (!m_active) begin
                p = rr_pick();
                if (p >= 0) begin
                    m_active  = 1'b1;
                    m_age     = 1;
                    m_g       = p;
                    m_op      = bus.req_op[2*p +: 2];
                    m_num     = bus.req_num[W*p +: W];
                    m_ptr     = (p + 1) % NREQ;
                    ref_acc   = calc(ref_acc, m_op, m_num);
                    m_pending = ref_acc;
                    grant_q.push_back(p);
                    acc_cyc_q.push_back(cyc);
                end
            end else if (m_age >= 3 && bus.resp_ready[m_g]) begin
                m_active = 1'b0;
                m_cnt    = m_cnt + 8'd1;
                data_q.push_back(int'(m_shown));
                hs_cyc_q.push_back(cyc);
                $display("txn req=%0d op=%0d num=%0d data=%0d count=%0d", m_g, m_op, m_num, m_shown, m_cnt);
            end else begin
                m_age++;
                if (m_age == 3) m_shown = m_pending;
            end
        end
    end

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rr, exp_rv;
        int p;
        if (m_valid) begin
            exp_rr = '0;
            exp_rv = '0;
            if (!m_active && rst_n) begin
                p = rr_pick();
                if (p >= 0) exp_rr[p] = 1'b1;
            end
            if (m_active && m_age >= 3) exp_rv[m_g] = 1'b1;
            chk("req_ready",  32'(bus.req_ready),  32'(exp_rr));
            chk("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
            chk("resp_data",  32'(bus.resp_data),  32'(m_shown));
            chk("calc_num",   32'(bus.calc_num),   32'(m_num));
            chk("calc_op",    32'(bus.calc_op),    32'(m_op));
            chk("calc_enter", 32'(bus.calc_enter), 32'(m_active && m_age == 1));
            chk("busy",       32'(bus.busy),       32'(m_active));
            chk("txn_count",  32'(bus.txn_count),  32'(m_cnt));
        end
    end

    function automatic int gq(int i);
        return (i < grant_q.size()) ? grant_q[i] : -1;
    endfunction
    function automatic int dq(int i);
        return (i < data_q.size()) ? data_q[i] : -1;
    endfunction
    function automatic int ad(int i);
        return (i + 1 < acc_cyc_q.size()) ? acc_cyc_q[i+1] - acc_cyc_q[i] : -1;
    endfunction

    task automatic clear_logs();
        grant_q.delete();
        acc_cyc_q.delete();
        hs_cyc_q.delete();
        data_q.delete();
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]         = (rem[i] > 0);
            bus.req_op[2*i +: 2]     = cmd_op[i];
            bus.req_num[W*i +: W]    = cmd_num[i];
        end
        bus.resp_ready = rready;
    endtask

    task automatic step();
        logic [NREQ-1:0] hs;
        @(negedge clk);
        hs = bus.req_ready & bus.req_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i] && rem[i] > 0) rem[i]--;
        end
        drive();
    endtask

    task automatic run_idle(input int budget);
        int n;
        bit pending;
        n = 0;
        pending = 1'b1;
        while (pending && n < budget) begin
            step();
            n++;
            pending = bus.busy;
            for (int i = 0; i < NREQ; i++) if (rem[i] > 0) pending = 1'b1;
        end
        chk("run_done", 32'(!pending), 32'd1);
    endtask

    task automatic load_core(input logic [W-1:0] v);
        core_load_val = v;
        core_load     = 1'b1;
        step();
        core_load     = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] held_d;
        logic [7:0]   held_c;
        bit           saw_rr, found;

        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 0; cmd_op[i] = '0; cmd_num[i] = '0;
        end
        rready        = '1;
        core_load     = 1'b1;
        core_load_val = '0;
        rst_n         = 1'b0;
        drive();

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        core_load = 1'b0;
        repeat (4) step();
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_txn",  32'(bus.txn_count), 32'd0);
        chk("idle_data", 32'(bus.resp_data), 32'd0);

        // Single ADD 5 on acc 0
        clear_logs();
        cmd_op[0] = 2'd0; cmd_num[0] = 8'd5; rem[0] = 1;
        drive();
        run_idle(40);
        chk("single_grant",   32'(gq(0)), 32'd0);
        chk("single_data",    32'(dq(0)), 32'd5);
        chk("single_latency", 32'((hs_cyc_q.size() > 0 && acc_cyc_q.size() > 0) ? hs_cyc_q[0] - acc_cyc_q[0] : -1), 32'd3);
        chk("single_txn",     32'(bus.txn_count), 32'd1);

        // Round-robin ADD 3 / SUB 1 from a fresh pointer and acc 0
        pulse_reset();
        load_core(8'd0);
        clear_logs();
        cmd_op[0] = 2'd0; cmd_num[0] = 8'd3; rem[0] = 2;
        cmd_op[1] = 2'd1; cmd_num[1] = 8'd1; rem[1] = 2;
        drive();
        run_idle(60);
        for (int i = 0; i < 4; i++) chk("rr_grant", 32'(gq(i)), 32'(i % 2));
        chk("rr_data0", 32'(dq(0)), 32'd3);
        chk("rr_data1", 32'(dq(1)), 32'd2);
        chk("rr_data2", 32'(dq(2)), 32'd5);
        chk("rr_data3", 32'(dq(3)), 32'd4);
        for (int i = 0; i < 3; i++) chk("rr_interval", 32'(ad(i)), 32'd4);

        // Backpressure on requester 1 (acc 4 carried over)
        clear_logs();
        rready = 2'b01;
        rem[0] = 2; rem[1] = 1;
        drive();
        found = 1'b0;
        for (int n = 0; n < 30 && !found; n++) begin
            step();
            found = bus.resp_valid[1];
        end
        chk("bp_found", 32'(found), 32'd1);
        held_d = bus.resp_data;
        held_c = bus.txn_count;
        saw_rr = 1'b0;
        repeat (6) begin
            step();
            saw_rr = saw_rr | (|bus.req_ready);
            chk("bp_valid", 32'(bus.resp_valid), 32'b10);
            chk("bp_data",  32'(bus.resp_data),  32'(held_d));
            chk("bp_txn",   32'(bus.txn_count),  32'(held_c));
        end
        chk("bp_no_ready", 32'(saw_rr), 32'd0);
        rready = '1;
        drive();
        run_idle(40);
        chk("bp_grant0", 32'(gq(0)), 32'd0);
        chk("bp_grant1", 32'(gq(1)), 32'd1);
        chk("bp_grant2", 32'(gq(2)), 32'd0);
        chk("bp_data0",  32'(dq(0)), 32'd7);
        chk("bp_data1",  32'(dq(1)), 32'd6);
        chk("bp_data2",  32'(dq(2)), 32'd9);
        chk("bp_txn_final", 32'(bus.txn_count), 32'(held_c + 8'd2));

        // Wrap and EQ
        load_core(8'd250);
        clear_logs();
        cmd_op[0] = 2'd0; cmd_num[0] = 8'd10; rem[0] = 1; drive(); run_idle(20);
        cmd_op[0] = 2'd3; cmd_num[0] = 8'd4;  rem[0] = 1; drive(); run_idle(20);
        cmd_op[0] = 2'd3; cmd_num[0] = 8'd7;  rem[0] = 1; drive(); run_idle(20);
        chk("wrap_add", 32'(dq(0)), 32'd4);
        chk("eq_true",  32'(dq(1)), 32'd1);
        chk("eq_false", 32'(dq(2)), 32'd0);

        // txn_count wraps after 256 transactions
        pulse_reset();
        chk("cnt_reset", 32'(bus.txn_count), 32'd0);
        cmd_op[0] = 2'd0; cmd_num[0] = 8'd1; rem[0] = 255;
        drive();
        run_idle(1100);
        chk("cnt_255", 32'(bus.txn_count), 32'd255);
        rem[0] = 1;
        drive();
        run_idle(20);
        chk("cnt_wrap", 32'(bus.txn_count), 32'd0);

        // Reset during ISSUE
        rem[0] = 1; rem[1] = 1;
        drive();
        found = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            @(negedge clk);
            found = bus.calc_enter;
        end
        chk("mid_found", 32'(found), 32'd1);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_enter", 32'(bus.calc_enter), 32'd0);
        chk("mid_rv",    32'(bus.resp_valid), 32'd0);
        chk("mid_busy",  32'(bus.busy), 32'd0);
        chk("mid_rr",    32'(bus.req_ready), 32'd0);
        clear_logs();
        rem[0] = 1; rem[1] = 1;
        rst_n = 1'b1;
        drive();
        run_idle(40);
        chk("mid_first_grant",  32'(gq(0)), 32'd0);
        chk("mid_second_grant", 32'(gq(1)), 32'd1);

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/calc_arbiter.md
Name: calc_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one accumulator calculator core between NREQ requesters.
- Each accepted command (op, operand) is driven into the core's NumIn/OpIn/Enter inputs with a correctly shaped Enter pulse.
- The core's updated accumulator is captured and returned to the winning requester over a valid/ready response channel.
- Sits between the requester ports and the calculator core, which keeps its own accumulator.

Parameters:
- NREQ, 2, number of requesters (2..8).
- W, 8, operand/result width; must match the core.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- req_valid  in  NREQ  per-requester command valid.
- req_ready  out  NREQ  per-requester accept strobe; at most one bit high per cycle.
- req_op  in  2*NREQ  per-requester op; slice i = [2i+1:2i]; ADD=0, SUB=1, OR=2, EQ=3.
- req_num  in  W*NREQ  per-requester operand; slice i = [W*i+W-1:W*i].
- resp_valid  out  NREQ  one-hot response valid to the granted requester.
- resp_ready  in  NREQ  per-requester response ready.
- resp_data  out  W  captured core result; shared by all requesters, qualified by resp_valid.
- calc_num  out  W  operand to core NumIn.
- calc_op  out  2  op to core OpIn.
- calc_enter  out  1  Enter strobe to core; registered output.
- calc_result  in  W  core NumOut (accumulator).
- busy  out  1  high in every state except IDLE.
- txn_count  out  8  count of completed transactions; wraps 255->0.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, priority pointer=0.
  - All outputs 0: req_ready, resp_valid, resp_data, calc_num, calc_op, calc_enter, busy, txn_count.
  - Reset overrides any in-flight transaction. Pending response is dropped; no req_ready is issued that cycle.
  - The core's accumulator is not reset by this block.
- State machine: IDLE -> ISSUE -> SETTLE -> RESP -> IDLE.
- IDLE:
  - If any req_valid: pick the first set bit scanning from pointer upward, modulo NREQ.
  - Assert req_ready[g] combinationally this cycle (handshake completes in this cycle).
  - Latch req_op/req_num slice g into calc_op/calc_num. Record g. Set pointer=(g+1) mod NREQ.
  - Next state ISSUE. If no req_valid, stay in IDLE.
- ISSUE: calc_enter=1 for exactly one cycle. The core updates its accumulator on the closing edge. Next state SETTLE.
- SETTLE: calc_enter=0. At the closing edge, resp_data<=calc_result. Next state RESP.
- RESP:
  - resp_valid[g]=1 and resp_data held stable until resp_ready[g]=1.
  - On handshake: txn_count+=1, next state IDLE. resp_ready from non-granted requesters is ignored.
- calc_num/calc_op hold their latched values from ISSUE through RESP. They update only at an IDLE accept.
- Enter shaping:
  - calc_enter is never high in two consecutive cycles.
  - It is low for at least 2 cycles (SETTLE, RESP) between pulses, so every pulse is a distinct rising edge to the core.
- Latency:
  - Accept (IDLE) to resp_valid is 3 cycles.
  - With resp_ready tied high, minimum initiation interval is 4 cycles per transaction.
- Fairness:
  - A requester that keeps req_valid high is granted within NREQ transactions.
  - With all requesters valid, grants rotate 0,1,...,NREQ-1,0.
- Requesters may change req_op/req_num freely when not being accepted. Only the acceptance-cycle values are used.
- Arithmetic is performed by the core (W-bit wrap for ADD/SUB; EQ yields 1/0). This block does no arithmetic except txn_count.

Test Plan:
- Reset then idle: rst_n low 2 cycles, no req_valid -> all outputs 0, busy=0, calc_enter never pulses.
- Single ADD: core acc=0; req 0 sends ADD 8'd5, resp_ready=1 -> req_ready[0] in accept cycle; calc_enter high exactly 1 cycle; resp_valid[0] 3 cycles later with resp_data=5; txn_count=1.
- Round-robin: both requesters hold valid, req0 ADD 3, req1 SUB 1, resp_ready=1 -> grants 0,1,0,1; resp_data 3,2,5,4; next accept exactly 4 cycles after the previous one.
- Backpressure: resp_ready[1]=0 for 6 cycles during req1 response -> resp_valid[1] and resp_data held constant; no new req_ready; txn_count increments only on the handshake.
- Wrap and EQ: acc=250, ADD 10 -> resp_data=4; then EQ 4 -> 1; then EQ 7 -> 0. Drive 256 transactions -> txn_count returns to 0.
- Reset mid-operation: assert rst_n=0 during ISSUE -> next cycle state IDLE, calc_enter=0, resp_valid=0, pointer=0; the next accept after reset goes to req 0 when both are valid.
